mem_req_queue: RTL
==================

MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of 2, at least 2.
REQ-002 Parameter MAX_OUTSTANDING, default 8, cap on issued-but-unanswered requests; SHALL be at least 1.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 in_req_val  in  1  request from crossbar mem side valid.
REQ-006 in_req_rdy  out  1  queue accepts request.
REQ-007 in_req_rw  in  2  {htif, rw} as produced by crossbar.
REQ-008 in_req_addr  in  `MEM_ADDR_BITS  request address.
REQ-009 in_req_data  in  `MEM_DATA_BITS  write data.
REQ-010 in_req_tag  in  `MEM_L2TAG_BITS  source-prefixed tag.
REQ-011 out_req_val / out_req_rdy / out_req_rw / out_req_addr / out_req_data / out_req_tag  out/in/out/out/out/out  same widths  request to L2 memory.
REQ-012 l2_resp_val, l2_resp_nack  in  1 each  L2 response / negative ack.
REQ-013 l2_resp_data  in  `MEM_DATA_BITS;  l2_resp_tag  in  `MEM_L2TAG_BITS.
REQ-014 xb_resp_val, xb_resp_nack, xb_resp_data, xb_resp_tag  out  same widths  response toward crossbar.
REQ-015 occupancy  out  clog2(DEPTH)+1  current FIFO entry count.
REQ-016 outstanding  out  clog2(MAX_OUTSTANDING)+1  issued, unanswered requests.
REQ-017 err_underflow  out  1  sticky: response arrived with outstanding==0.

Function
REQ-018 Enqueue SHALL occur on cycles with in_req_val & in_req_rdy; the entry stores {rw, addr, data, tag} unchanged.
REQ-019 in_req_rdy SHALL equal (occupancy < DEPTH); no same-cycle dequeue bypass when full.
REQ-020 out_req_val SHALL equal (occupancy != 0) & (outstanding < MAX_OUTSTANDING).
REQ-021 out_req_rw/addr/data/tag SHALL present the head entry directly from storage; no empty-queue bypass, so minimum enqueue-to-out_req_val latency is 1 cycle.
REQ-022 Issue SHALL occur on out_req_val & out_req_rdy: head pointer advances, outstanding increments.
REQ-023 Order SHALL be strict FIFO; head fields SHALL remain stable while out_req_val & ~out_req_rdy.
REQ-024 Read/write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 Simultaneous enqueue and issue SHALL leave occupancy unchanged.
REQ-026 A completion is a cycle with l2_resp_val | l2_resp_nack; each completion SHALL decrement outstanding by 1 (both asserted counts as one).
REQ-027 Simultaneous issue and completion SHALL leave outstanding unchanged.
REQ-028 Completion with outstanding==0 and no same-cycle issue SHALL leave outstanding at 0 and set err_underflow.
REQ-029 xb_resp_* SHALL equal l2_resp_* combinationally, zero latency, unaffected by err_underflow.
REQ-030 NACKed requests SHALL NOT be replayed by this block; retry is the requester's duty.

Reset
REQ-031 While reset_n is low: pointers, occupancy, outstanding and err_underflow SHALL be 0; in_req_rdy 1; out_req_val 0.
REQ-032 Reset mid-operation SHALL discard all queued entries and outstanding count; storage contents need not be cleared.
REQ-033 err_underflow SHALL clear only on reset.

Structure
REQ-034 Width macros (`MEM_ADDR_BITS, `MEM_DATA_BITS, `MEM_L2TAG_BITS) SHALL come from riscvConst.vh; no local redefinition.
REQ-035 Storage and pointers SHALL live in one sub-module, mem_req_fifo (parameterised width and depth); the outstanding counter and handshake gating stay in mem_req_queue.

Verification
REQ-036 Reset release, in_req_val=0 for 5 cycles -> in_req_rdy=1, out_req_val=0, occupancy=0, outstanding=0.
REQ-037 Enqueue tags 0x01..0x04 back-to-back with out_req_rdy=0 -> occupancy=4, in_req_rdy=0; raise out_req_rdy -> tags issue in order 0x01..0x04 over 4 cycles.
REQ-038 MAX_OUTSTANDING=2, 3 queued, out_req_rdy=1, no responses -> exactly 2 issue, out_req_val=0, outstanding=2; one l2_resp_val -> third issues next cycle.
REQ-039 Issue and l2_resp_nack on same cycle with outstanding=1 -> outstanding stays 1; xb_resp_nack=1 same cycle with tag passed through.
REQ-040 l2_resp_val with outstanding=0 -> err_underflow=1 and stays 1; outstanding=0; xb_resp_val=1 same cycle.
REQ-041 Assert reset_n low with occupancy=3, outstanding=2 -> all counters 0 immediately (asynchronous), out_req_val=0.

Source files
------------

// File: rtl/mem_req_queue_pkg.sv
// Types shared by the crossbar-to-L2 request queue and its storage FIFO.
`include "riscvConst.vh"

package mem_req_queue_pkg;

    localparam int ADDR_W = `MEM_ADDR_BITS;
    localparam int DATA_W = `MEM_DATA_BITS;
    localparam int TAG_W  = `MEM_L2TAG_BITS;

    // One queued request exactly as the crossbar presented it.
    typedef struct packed {
        logic [1:0]        rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } mem_req_t;

    localparam int REQ_W = $bits(mem_req_t);

endpackage

// File: rtl/mem_req_fifo.sv
// Circular-buffer FIFO: storage, read/write pointers and entry count.
// Callers must only push when not full and only pop when not empty.
module mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count and pointers alone
    // decide which entries are valid, and this keeps the array in plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/riscvConst.vh
// Shared memory-interface widths used by the crossbar/L2 request path.
`ifndef RISCV_CONST_VH
`define RISCV_CONST_VH
`define MEM_ADDR_BITS  26
`define MEM_DATA_BITS  128
`define MEM_L2TAG_BITS 6
`endif

// File: rtl/mem_req_queue.sv
// Request queue between the crossbar memory port and L2, throttled by a
// cap on outstanding requests; L2 responses pass straight back to the crossbar.
`include "riscvConst.vh"

module mem_req_queue
    import mem_req_queue_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,

    input  logic                              in_req_val,
    output logic                              in_req_rdy,
    input  logic [1:0]                        in_req_rw,
    input  logic [`MEM_ADDR_BITS-1:0]         in_req_addr,
    input  logic [`MEM_DATA_BITS-1:0]         in_req_data,
    input  logic [`MEM_L2TAG_BITS-1:0]        in_req_tag,

    output logic                              out_req_val,
    input  logic                              out_req_rdy,
    output logic [1:0]                        out_req_rw,
    output logic [`MEM_ADDR_BITS-1:0]         out_req_addr,
    output logic [`MEM_DATA_BITS-1:0]         out_req_data,
    output logic [`MEM_L2TAG_BITS-1:0]        out_req_tag,

    input  logic                              l2_resp_val,
    input  logic                              l2_resp_nack,
    input  logic [`MEM_DATA_BITS-1:0]         l2_resp_data,
    input  logic [`MEM_L2TAG_BITS-1:0]        l2_resp_tag,

    output logic                              xb_resp_val,
    output logic                              xb_resp_nack,
    output logic [`MEM_DATA_BITS-1:0]         xb_resp_data,
    output logic [`MEM_L2TAG_BITS-1:0]        xb_resp_tag,

    output logic [$clog2(DEPTH):0]            occupancy,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic                              err_underflow
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    mem_req_t in_req;
    mem_req_t head;
    logic     enq;
    logic     issue;
    logic     completion;

    assign in_req.rw   = in_req_rw;
    assign in_req.addr = in_req_addr;
    assign in_req.data = in_req_data;
    assign in_req.tag  = in_req_tag;

    assign in_req_rdy  = (occupancy < OCC_W'(DEPTH));
    assign out_req_val = (occupancy != '0) && (outstanding < OUT_W'(MAX_OUTSTANDING));

    assign enq        = in_req_val & in_req_rdy;
    assign issue      = out_req_val & out_req_rdy;
    assign completion = l2_resp_val | l2_resp_nack;

    mem_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (enq),
        .pop     (issue),
        .wdata   (in_req),
        .rdata   (head),
        .count   (occupancy)
    );

    assign out_req_rw   = head.rw;
    assign out_req_addr = head.addr;
    assign out_req_data = head.data;
    assign out_req_tag  = head.tag;

    // Responses are forwarded untouched; NACK retry belongs to the requester.
    assign xb_resp_val  = l2_resp_val;
    assign xb_resp_nack = l2_resp_nack;
    assign xb_resp_data = l2_resp_data;
    assign xb_resp_tag  = l2_resp_tag;

    // A completion with nothing in flight is clamped at zero and flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else if (issue && !completion) begin
            outstanding <= outstanding + OUT_W'(1);
        end else if (!issue && completion) begin
            if (outstanding == '0) err_underflow <= 1'b1;
            else                   outstanding   <= outstanding - OUT_W'(1);
        end
    end

endmodule
